mem_write_checker: RTL and testbench

Parametrised, synthesizable end-of-test checker for the pipelined MIPS system. It monitors the data-memory write port (`memwrite`, `dataadr`, `writedata`) and matches writes against an ordered table of expected (address, data) pairs that is loaded before the run. Writes to one designated scratch address are tolerated, and a cycle timeout is enforced. The block reports pass/fail, a failure code and the failing write, so the same check can run in simulation or on an FPGA with LEDs instead of `$display`.

---
 rtl/mem_write_checker.sv | 197 +++++++++++++++++++
 tb/tb_mem_write_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// -----------------------------------------------------------------------------
// mem_write_checker
//   End-of-test checker for the pipelined MIPS system. It watches the data
//   memory write port and matches each write, in order, against a table of
//   expected (address, data) pairs loaded before the run. Writes to one
//   scratch address are tolerated. An optional cycle timeout bounds the run.
//   Results are held in registers, so they can drive LEDs on an FPGA as well
//   as being read by a simulation bench.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   cfg_we/idx/adr/data   table write (IDLE/PASS/FAIL only)
//   cfg_num          number of expected writes, sampled on start
//   start            begin a run (IDLE/PASS/FAIL only)
//   memwrite/dataadr/writedata   monitored write port
//   busy, done, pass run status
//   fail_code        0 none, 1 unexpected address, 2 data mismatch, 3 timeout
//   match_cnt        expected writes matched so far
//   cycles           RUN cycles elapsed, saturating
//   fail_adr/fail_data    failing write (0 on timeout)
// -----------------------------------------------------------------------------
module mem_write_checker #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int IGNORE_ADR = 80,
    parameter int TIMEOUT    = 4096,
    parameter int CNTW       = 16,
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_adr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [IW:0]      cfg_num,
    input  logic             start,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [IW:0]      match_cnt,
    output logic [CNTW-1:0]  cycles,
    output logic [WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0] fail_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] IGN_ADR = WIDTH'(IGNORE_ADR);
    // Value of the cycle counter during the last allowed RUN cycle.
    localparam logic [CNTW-1:0]  TO_LAST = CNTW'(TIMEOUT - 1);
    localparam logic             TO_EN   = (TIMEOUT != 0);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [1:0]       r_fail_code;
    logic [IW:0]      r_match_cnt;
    logic [IW:0]      r_num;
    logic [CNTW-1:0]  r_cycles;
    logic [WIDTH-1:0] r_fail_adr;
    logic [WIDTH-1:0] r_fail_data;
    logic [WIDTH-1:0] r_tab_adr  [DEPTH];
    logic [WIDTH-1:0] r_tab_data [DEPTH];

    logic [IW-1:0]    w_idx;
    logic [IW:0]      w_match_next;
    logic             w_hit_adr;
    logic             w_hit_data;
    logic             w_timeout;
    logic             w_cfg_ok;

    // The match counter can legally reach the latched count, which may exceed
    // DEPTH-1; clamp so the table read never goes out of range.
    always_comb begin
        w_idx = r_match_cnt[IW-1:0];
        if (r_match_cnt >= (IW+1)'(DEPTH))
            w_idx = IW'(DEPTH - 1);
    end

    assign w_match_next = r_match_cnt + 1'b1;
    assign w_hit_adr    = (dataadr   == r_tab_adr[w_idx]);
    assign w_hit_data   = (writedata == r_tab_data[w_idx]);
    assign w_timeout    = TO_EN && (r_cycles == TO_LAST);
    // Indices beyond the table (non power-of-two DEPTH) are dropped.
    assign w_cfg_ok     = (32'(cfg_idx) < DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= 2'd0;
            r_match_cnt <= '0;
            r_num       <= '0;
            r_cycles    <= '0;
            r_fail_adr  <= '0;
            r_fail_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_adr[i]  <= '0;
                r_tab_data[i] <= '0;
            end
        end else begin
            // Table write; with a simultaneous start it lands before the
            // first RUN cycle reads the table.
            if (cfg_we && (r_state != S_RUN) && w_cfg_ok) begin
                r_tab_adr[cfg_idx]  <= cfg_adr;
                r_tab_data[cfg_idx] <= cfg_data;
            end

            case (r_state)
                S_RUN: begin
                    if (r_cycles != '1)
                        r_cycles <= r_cycles + 1'b1;

                    if (memwrite && w_hit_adr && w_hit_data) begin
                        r_match_cnt <= w_match_next;
                        if (w_match_next == r_num) begin
                            r_state <= S_PASS;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else if (w_timeout) begin
                            r_state     <= S_FAIL;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_fail_code <= 2'd3;
                        end
                    end else if (memwrite && w_hit_adr) begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= 2'd2;
                        r_fail_adr  <= dataadr;
                        r_fail_data <= writedata;
                    end else if (memwrite && (dataadr != IGN_ADR)) begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= 2'd1;
                        r_fail_adr  <= dataadr;
                        r_fail_data <= writedata;
                    end else if (w_timeout) begin
                        // No write, or a tolerated scratch write.
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= 2'd3;
                    end
                end

                default: begin  // IDLE, PASS, FAIL
                    if (start) begin
                        r_num       <= cfg_num;
                        r_match_cnt <= '0;
                        r_cycles    <= '0;
                        r_fail_code <= 2'd0;
                        r_fail_adr  <= '0;
                        r_fail_data <= '0;
                        if (cfg_num == '0) begin
                            r_state <= S_PASS;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_code = r_fail_code;
    assign match_cnt = r_match_cnt;
    assign cycles    = r_cycles;
    assign fail_adr  = r_fail_adr;
    assign fail_data = r_fail_data;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int IW    = 2;
    localparam int CNTW  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [WIDTH-1:0] cfg_adr;
    logic [WIDTH-1:0] cfg_data;
    logic [IW:0]      cfg_num;
    logic             start;
    logic             memwrite;
    logic [WIDTH-1:0] dataadr;
    logic [WIDTH-1:0] writedata;
    logic             busy;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic [IW:0]      match_cnt;
    logic [CNTW-1:0]  cycles;
    logic [WIDTH-1:0] fail_adr;
    logic [WIDTH-1:0] fail_data;

    int n_cmp = 0;
    int n_err = 0;

    mem_write_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IGNORE_ADR(80), .TIMEOUT(16), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .cfg_num(cfg_num), .start(start),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
        .match_cnt(match_cnt), .cycles(cycles),
        .fail_adr(fail_adr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int adr, input int data);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_adr = adr; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input int num);
        start = 1'b1; cfg_num = (IW+1)'(num);
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input int adr, input int data);
        memwrite = 1'b1; dataadr = adr; writedata = data;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_cmp++; if ({busy, done, pass} !== 3'b000) begin n_err++; $display("FAIL reset.flags got %b want 000", {busy, done, pass}); end
        n_cmp++; if (fail_code !== 2'd0) begin n_err++; $display("FAIL reset.fail_code got %0d want 0", fail_code); end
        n_cmp++; if (cycles !== 16'd0 || match_cnt !== 3'd0) begin n_err++; $display("FAIL reset.counts got cyc=%0d match=%0d want 0/0", cycles, match_cnt); end
        n_cmp++; if (fail_adr !== 32'd0 || fail_data !== 32'd0) begin n_err++; $display("FAIL reset.fail_wr got %0d/%0d want 0/0", fail_adr, fail_data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pass_scratch();
        load(0, 84, 666);
        go(1);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL scratch.start got busy=%b done=%b want 1/0", busy, done); end
        wr(80, 7);
        n_cmp++; if (busy !== 1'b1 || match_cnt !== 3'd0) begin n_err++; $display("FAIL scratch.ignore got busy=%b match=%0d want 1/0", busy, match_cnt); end
        wr(84, 666);
        n_cmp++; if ({busy, done, pass} !== 3'b011) begin n_err++; $display("FAIL scratch.pass got bdp=%b want 011", {busy, done, pass}); end
        n_cmp++; if (match_cnt !== 3'd1 || fail_code !== 2'd0) begin n_err++; $display("FAIL scratch.result got match=%0d code=%0d want 1/0", match_cnt, fail_code); end
        n_cmp++; if (cycles !== 16'd2) begin n_err++; $display("FAIL scratch.cycles got %0d want 2", cycles); end
        // Writes after PASS are ignored.
        wr(4, 4);
        n_cmp++; if (pass !== 1'b1 || fail_code !== 2'd0) begin n_err++; $display("FAIL scratch.hold got pass=%b code=%0d want 1/0", pass, fail_code); end
    endtask

    task automatic test_mismatch();
        go(1);
        wr(84, 665);
        n_cmp++; if ({busy, done, pass} !== 3'b010) begin n_err++; $display("FAIL mismatch.flags got bdp=%b want 010", {busy, done, pass}); end
        n_cmp++; if (fail_code !== 2'd2) begin n_err++; $display("FAIL mismatch.code got %0d want 2", fail_code); end
        n_cmp++; if (fail_adr !== 32'd84 || fail_data !== 32'd665) begin n_err++; $display("FAIL mismatch.fail_wr got %0d/%0d want 84/665", fail_adr, fail_data); end
    endtask

    task automatic test_order();
        load(1, 88, 1);
        go(2);
        wr(88, 1);
        n_cmp++; if (fail_code !== 2'd1 || fail_adr !== 32'd88 || fail_data !== 32'd1) begin n_err++; $display("FAIL order.unexp got code=%0d adr=%0d data=%0d want 1/88/1", fail_code, fail_adr, fail_data); end
        n_cmp++; if (done !== 1'b1 || pass !== 1'b0) begin n_err++; $display("FAIL order.flags got done=%b pass=%b want 1/0", done, pass); end
        go(2);
        n_cmp++; if (fail_code !== 2'd0 || fail_adr !== 32'd0 || busy !== 1'b1) begin n_err++; $display("FAIL order.restart got code=%0d adr=%0d busy=%b want 0/0/1", fail_code, fail_adr, busy); end
        wr(84, 666);
        n_cmp++; if (match_cnt !== 3'd1 || busy !== 1'b1) begin n_err++; $display("FAIL order.first got match=%0d busy=%b want 1/1", match_cnt, busy); end
        wr(88, 1);
        n_cmp++; if (pass !== 1'b1 || match_cnt !== 3'd2) begin n_err++; $display("FAIL order.pass got pass=%b match=%0d want 1/2", pass, match_cnt); end
    endtask

    task automatic test_timeout();
        go(1);
        for (int i = 0; i < 15; i++) tick();
        n_cmp++; if (busy !== 1'b1 || cycles !== 16'd15) begin n_err++; $display("FAIL timeout.last got busy=%b cyc=%0d want 1/15", busy, cycles); end
        tick();
        n_cmp++; if (fail_code !== 2'd3 || done !== 1'b1 || pass !== 1'b0) begin n_err++; $display("FAIL timeout.code got code=%0d done=%b pass=%b want 3/1/0", fail_code, done, pass); end
        n_cmp++; if (cycles !== 16'd16) begin n_err++; $display("FAIL timeout.cycles got %0d want 16", cycles); end
        n_cmp++; if (fail_adr !== 32'd0 || fail_data !== 32'd0) begin n_err++; $display("FAIL timeout.fail_wr got %0d/%0d want 0/0", fail_adr, fail_data); end
        // Completing match in the last allowed cycle wins over timeout.
        go(1);
        for (int i = 0; i < 15; i++) tick();
        wr(84, 666);
        n_cmp++; if (pass !== 1'b1 || fail_code !== 2'd0 || cycles !== 16'd16) begin n_err++; $display("FAIL timeout.prec got pass=%b code=%0d cyc=%0d want 1/0/16", pass, fail_code, cycles); end
    endtask

    task automatic test_ignored_in_run();
        go(2);
        // start with cfg_num=0 and a table overwrite must both be dropped.
        start = 1'b1; cfg_num = 3'd0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_adr = 84; cfg_data = 999;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        n_cmp++; if (busy !== 1'b1 || cycles !== 16'd1) begin n_err++; $display("FAIL ignored.run got busy=%b cyc=%0d want 1/1", busy, cycles); end
        wr(84, 666);
        n_cmp++; if (match_cnt !== 3'd1 || busy !== 1'b1) begin n_err++; $display("FAIL ignored.table got match=%0d busy=%b want 1/1", match_cnt, busy); end
        wr(88, 1);
        n_cmp++; if (pass !== 1'b1 || match_cnt !== 3'd2) begin n_err++; $display("FAIL ignored.pass got pass=%b match=%0d want 1/2", pass, match_cnt); end
    endtask

    task automatic test_num_zero();
        go(0);
        n_cmp++; if ({busy, done, pass} !== 3'b011 || cycles !== 16'd0) begin n_err++; $display("FAIL zero.pass got bdp=%b cyc=%0d want 011/0", {busy, done, pass}, cycles); end
        n_cmp++; if (match_cnt !== 3'd0) begin n_err++; $display("FAIL zero.match got %0d want 0", match_cnt); end
    endtask

    task automatic test_we_with_start();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_adr = 84; cfg_data = 555;
        start = 1'b1; cfg_num = 3'd1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        wr(84, 555);
        n_cmp++; if (pass !== 1'b1 || match_cnt !== 3'd1) begin n_err++; $display("FAIL we_start.pass got pass=%b match=%0d want 1/1", pass, match_cnt); end
    endtask

    task automatic test_reset_midrun();
        go(2);
        wr(84, 555);
        n_cmp++; if (match_cnt !== 3'd1 || busy !== 1'b1) begin n_err++; $display("FAIL midrun.pre got match=%0d busy=%b want 1/1", match_cnt, busy); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({busy, done, pass} !== 3'b000 || match_cnt !== 3'd0 || cycles !== 16'd0) begin n_err++; $display("FAIL midrun.async got bdp=%b match=%0d cyc=%0d want 000/0/0", {busy, done, pass}, match_cnt, cycles); end
        reset = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrun.idle got busy=%b done=%b want 0/0", busy, done); end
        go(1);
        wr(0, 0);
        n_cmp++; if (pass !== 1'b1 || match_cnt !== 3'd1) begin n_err++; $display("FAIL midrun.cleared got pass=%b match=%0d want 1/1", pass, match_cnt); end
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0;
        cfg_num = '0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        test_reset();
        test_pass_scratch();
        test_mismatch();
        test_order();
        test_timeout();
        test_ignored_in_run();
        test_num_zero();
        test_we_with_start();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
